mfcc_coef_writer: RTL and testbench



---
 rtl/mfcc_coef_writer_if.sv | 35 +++
 rtl/mfcc_coef_writer.sv | 172 +++++++++++++++++
 tb/tb_mfcc_coef_writer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_coef_writer_if.sv
// Coefficient input handshake, reader frame release and RAM write-port bundle
// for mfcc_coef_writer.
interface mfcc_coef_writer_if #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 14
);
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              in_last;
    logic              in_ready;
    logic              frame_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic [ADDR_W-1:0] frame_base;
    logic              frame_err;
    logic              sat_flag;
    logic [9:0]        frames_avail;

    // Upstream producer and downstream reader side.
    modport master (
        output in_valid, in_data, in_last, frame_ack,
        input  in_ready, wr_en, wr_addr, wr_data, frame_done, frame_base,
        input  frame_err, sat_flag, frames_avail
    );

    // Writer side.
    modport slave (
        input  in_valid, in_data, in_last, frame_ack,
        output in_ready, wr_en, wr_addr, wr_data, frame_done, frame_base,
        output frame_err, sat_flag, frames_avail
    );
endinterface

// File: rtl/mfcc_coef_writer.sv
// Saturates MFCC coefficients to RAM width and packs NCOEF per frame into a circular
// frame buffer, tracking unreleased frames and applying backpressure when full.
module mfcc_coef_writer #(
    parameter int unsigned IN_W       = 16,
    parameter int unsigned NCOEF      = 13,
    parameter int unsigned MAX_FRAMES = 630,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 14
) (
    input logic               wr_clk,
    input logic               tb_wr_rst,
    mfcc_coef_writer_if.slave bus
);

    localparam int unsigned IdxW   = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int unsigned AvailW = 10;

    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NCOEF - 1);
    localparam logic [ADDR_W-1:0] FrameStep = ADDR_W'(NCOEF);
    localparam logic [ADDR_W-1:0] LastBase  = ADDR_W'((MAX_FRAMES - 1) * NCOEF);
    localparam logic [AvailW-1:0] MaxAvail  = AvailW'(MAX_FRAMES);

    localparam int SatMax = (1 << (DATA_W - 1)) - 1;
    localparam int SatMin = -(1 << (DATA_W - 1));

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StFlush
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [AvailW-1:0]   avail_q, avail_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]   frame_base_q, frame_base_d;
    logic                frame_err_q, frame_err_d;
    logic                sat_flag_q, sat_flag_d;

    logic                accept;
    logic                commit;
    logic                ack_eff;
    logic signed [31:0]  in_ext;
    logic [DATA_W-1:0]   sat_data;
    logic                sat_hit;

    assign accept  = bus.in_valid && in_ready_q;
    // An ack with nothing outstanding is a reader bug; ignore it rather than wrap.
    assign ack_eff = bus.frame_ack && (avail_q != '0);

    always_comb begin
        in_ext   = {{(32 - IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        sat_hit  = 1'b0;
        sat_data = bus.in_data[DATA_W-1:0];
        if (in_ext > SatMax) begin
            sat_hit  = 1'b1;
            sat_data = DATA_W'(SatMax);
        end else if (in_ext < SatMin) begin
            sat_hit  = 1'b1;
            sat_data = DATA_W'(SatMin);
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        idx_d        = idx_q;
        commit       = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_base_d = frame_base_q;
        frame_err_d  = 1'b0;
        sat_flag_d   = 1'b0;

        case (state_q)
            StIdle, StCollect: begin
                if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = base_q + ADDR_W'(idx_q);
                    wr_data_d  = sat_data;
                    sat_flag_d = sat_hit;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (bus.in_last) begin
                            commit       = 1'b1;
                            frame_done_d = 1'b1;
                            frame_base_d = base_q;
                            base_d       = (base_q == LastBase) ? '0 : base_q + FrameStep;
                            state_d      = StIdle;
                        end else begin
                            // Overlong frame: keep the slot, drop the rest of it.
                            frame_err_d = 1'b1;
                            state_d     = StFlush;
                        end
                    end else if (bus.in_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = StCollect;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StCollect;
                    end
                end
            end
            StFlush: begin
                if (accept && bus.in_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        avail_d = avail_q;
        if (commit && !ack_eff) begin
            avail_d = avail_q + AvailW'(1);
        end else if (!commit && ack_eff) begin
            avail_d = avail_q - AvailW'(1);
        end
        // Look at the post-commit count so the frame just closed is already counted.
        in_ready_d = (state_d == StFlush) || (avail_d < MaxAvail);
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            idx_q        <= '0;
            avail_q      <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_base_q <= '0;
            frame_err_q  <= 1'b0;
            sat_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            avail_q      <= avail_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_base_q <= frame_base_d;
            frame_err_q  <= frame_err_d;
            sat_flag_q   <= sat_flag_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.frame_base   = frame_base_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.sat_flag     = sat_flag_q;
    assign bus.frames_avail = avail_q;

endmodule

// File: tb/tb_mfcc_coef_writer.sv
// Directed bench for mfcc_coef_writer: a small frame model feeds a scoreboard of
// expected RAM writes that a negedge monitor drains and compares.
module tb_mfcc_coef_writer;

    localparam int NCoef    = 13;
    localparam int LastBase = 8177;

    logic wr_clk    = 1'b0;
    logic tb_wr_rst = 1'b0;
    bit   mon_en    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [12:0] addr;
        logic [13:0] data;
        logic        sat;
        logic        done;
        logic        err;
        logic [12:0] base;
    } exp_t;

    exp_t sb[$];

    int m_base  = 0;
    int m_idx   = 0;
    bit m_flush = 1'b0;

    mfcc_coef_writer_if #(.IN_W(16), .ADDR_W(13), .DATA_W(14)) bus ();

    mfcc_coef_writer #(
        .IN_W(16), .NCOEF(13), .MAX_FRAMES(630), .ADDR_W(13), .DATA_W(14)
    ) dut (
        .wr_clk(wr_clk),
        .tb_wr_rst(tb_wr_rst),
        .bus(bus)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] sat_model(input logic [15:0] d);
        int v;
        v = $signed(d);
        if (v > 8191) return {1'b1, 14'h1FFF};
        if (v < -8192) return {1'b1, 14'h2000};
        return {1'b0, d[13:0]};
    endfunction

    always @(negedge wr_clk) begin
        if (mon_en && !tb_wr_rst) begin
            if (bus.wr_en) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_write: observed write to addr %0d, expected none",
                           bus.wr_addr);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", bus.wr_addr, e.addr);
                    check("wr_data", bus.wr_data, e.data);
                    check("sat_flag", bus.sat_flag, e.sat);
                    check("frame_done", bus.frame_done, e.done);
                    check("frame_err", bus.frame_err, e.err);
                    if (e.done) check("frame_base", bus.frame_base, e.base);
                end
            end else begin
                check("stray_pulse", {bus.frame_done, bus.frame_err, bus.sat_flag}, 3'b000);
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit last, input bit ack = 1'b0);
        int   waited;
        exp_t e;
        logic [14:0] s;
        waited = 0;
        @(negedge wr_clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge wr_clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", bus.in_ready, 1'b1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.frame_ack = ack;
        if (!m_flush) begin
            s      = sat_model(d);
            e.addr = 13'(m_base + m_idx);
            e.data = s[13:0];
            e.sat  = s[14];
            e.done = 1'b0;
            e.err  = 1'b0;
            e.base = 13'(m_base);
            if (m_idx == NCoef - 1) begin
                m_idx = 0;
                if (last) begin
                    e.done = 1'b1;
                    m_base = (m_base == LastBase) ? 0 : m_base + NCoef;
                end else begin
                    e.err   = 1'b1;
                    m_flush = 1'b1;
                end
            end else if (last) begin
                e.err = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
            sb.push_back(e);
        end else if (last) begin
            m_flush = 1'b0;
        end
        @(posedge wr_clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.frame_ack = 1'b0;
    endtask

    task automatic send_frame(input int seed);
        for (int i = 0; i < NCoef; i++) send(16'(seed + i), i == NCoef - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(negedge wr_clk);
        bus.frame_ack = 1'b1;
        @(posedge wr_clk);
        #1;
        bus.frame_ack = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge wr_clk);
        #1;
        tb_wr_rst    = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.frame_ack = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 13'd0);
        check("rst_wr_data", bus.wr_data, 14'd0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_frame_base", bus.frame_base, 13'd0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_sat_flag", bus.sat_flag, 1'b0);
        check("rst_frames_avail", bus.frames_avail, 10'd0);
        check("sb_drained_at_reset", sb.size(), 0);
        sb.delete();
        m_base  = 0;
        m_idx   = 0;
        m_flush = 1'b0;
        repeat (2) @(negedge wr_clk);
        tb_wr_rst = 1'b0;
        @(posedge wr_clk);
        #1;
        mon_en = 1'b1;
        check("ready_after_reset", bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] sat_vals [6];
        sat_vals = '{16'h7FFF, 16'h8000, 16'h1FFF, 16'hE000, 16'hDFFF, 16'h2000};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.frame_ack = 1'b0;

        apply_reset();

        // Single frame 0..12 at base 0.
        send_frame(0);
        idle(2);
        check("avail_single", bus.frames_avail, 10'd1);

        // Saturation and boundary values at the start of the second frame.
        foreach (sat_vals[k]) send(sat_vals[k], 1'b0);
        for (int i = 6; i < NCoef; i++) send(16'(i), i == NCoef - 1);
        idle(2);
        check("avail_after_sat", bus.frames_avail, 10'd2);

        send_frame(40);
        send_frame(60);
        idle(2);
        check("avail_four", bus.frames_avail, 10'd4);

        // Commit and ack on the same edge.
        for (int i = 0; i < NCoef; i++) send(16'(100 + i), i == NCoef - 1, i == NCoef - 1);
        idle(2);
        check("avail_commit_ack", bus.frames_avail, 10'd4);
        repeat (4) pulse_ack();
        idle(1);
        check("avail_drained", bus.frames_avail, 10'd0);
        pulse_ack();
        idle(1);
        check("avail_ack_at_zero", bus.frames_avail, 10'd0);
        check("ready_when_empty", bus.in_ready, 1'b1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send(16'(200 + i), 1'b0);
        apply_reset();

        // Short frame, then a good frame reusing base 0.
        for (int i = 0; i < 6; i++) send(16'(300 + i), i == 5);
        send_frame(320);
        idle(2);
        check("base_after_short", bus.frame_base, 13'd0);
        check("avail_after_short", bus.frames_avail, 10'd1);

        // Long frame, three flushed samples, then a good frame at base 13.
        for (int i = 0; i < NCoef; i++) send(16'(400 + i), 1'b0);
        send(16'h0AAA, 1'b0);
        check("ready_in_flush", bus.in_ready, 1'b1);
        send(16'h0BBB, 1'b0);
        send(16'h0CCC, 1'b1);
        send_frame(500);
        idle(2);
        check("base_after_long", bus.frame_base, 13'd13);
        check("avail_after_long", bus.frames_avail, 10'd2);

        // Fill every slot, wrap the base and check backpressure.
        apply_reset();
        for (int f = 0; f < 630; f++) begin
            for (int i = 0; i < NCoef; i++) send(16'($urandom), i == NCoef - 1);
        end
        idle(2);
        check("avail_full", bus.frames_avail, 10'd630);
        check("ready_full", bus.in_ready, 1'b0);
        check("base_last_slot", bus.frame_base, 13'd8177);
        @(negedge wr_clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0123;
        repeat (4) @(negedge wr_clk);
        bus.in_valid = 1'b0;
        check("ready_held_full", bus.in_ready, 1'b0);
        pulse_ack();
        idle(1);
        check("avail_after_ack", bus.frames_avail, 10'd629);
        check("ready_after_ack", bus.in_ready, 1'b1);
        send_frame(700);
        idle(2);
        check("base_wrapped", bus.frame_base, 13'd0);
        check("avail_full_again", bus.frames_avail, 10'd630);
        check("ready_full_again", bus.in_ready, 1'b0);

        idle(2);
        check("sb_empty_at_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish by 2 ms, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
